cpu_exec_sequencer: RTL and testbench
=====================================

Name: cpu_exec_sequencer

Overview:
Per-instruction execution state machine for the 8051 core. It fetches opcodes from ROM, presents them with a run phase to the instruction decoder, and consumes the decoder's next-status code. It then performs one ROM operand read, RAM read, ALU process step or RAM write per decoded step, owns the program counter, and arbitrates the single RAM/ROM request/acknowledge handshakes.

Parameters:
PC_W, 16, program counter / ROM address width
RESET_PC, 16'h0000, PC value after reset
ACK_TIMEOUT, 8'd15, max wait cycles for rom_ack/ram_ack/alu_done before abort (1..255)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
next_status  in  3  decoder step code: 000 NOP, 001 RAM_READ, 010 ROM_READ, 011 PROCESS, 100 RAM_WRITE, 111 NOT_DONE; 101/110 illegal
run_phase_init  in  3  decoder starting phase for the current opcode
data_from  in  3  write-data source: 000 accumulator, 001 data_register
addr_register_out  in  8  RAM address from decoder
acc  in  8  accumulator value
rom_ack  in  1  ROM transfer complete
rom_rdata  in  8  ROM read data
ram_ack  in  1  RAM transfer complete
ram_rdata  in  8  RAM read data
alu_done  in  1  ALU step complete
instruction  out  8  latched opcode, to decoder
run_phase  out  3  current execution phase, to decoder
pc  out  PC_W  program counter
rom_req  out  1  ROM read request
rom_addr  out  PC_W  ROM address
ram_req  out  1  RAM request
ram_we  out  1  RAM write enable, valid with ram_req
ram_addr  out  8  RAM address
ram_wdata  out  8  RAM write data
data_register  out  8  operand latch
alu_start  out  1  one-cycle ALU start pulse
bus_err  out  1  one-cycle timeout pulse
illegal_op  out  1  one-cycle illegal-status pulse

Behaviour:
- Reset (async): state FETCH; pc=RESET_PC; instruction=8'h00; run_phase=0; data_register=0; wait counter=0; all strobes/requests low; ram_addr/ram_wdata=0.
- States: FETCH, DECODE, ROM_OPND, RAM_RD, RAM_WR, ALU_WAIT. State and all outputs are registered.
- Handshake: req is high for the whole wait state. A transfer completes on the edge where req and ack are both high. req falls on the following cycle. ack with req low is ignored.
- FETCH: rom_req=1, rom_addr=pc. On rom_ack: instruction<=rom_rdata, pc<=pc+1 (wraps at 2^PC_W), run_phase<=0, first-decode flag set, go to DECODE.
- DECODE (exactly 1 cycle): if the first-decode flag is set, run_phase<=run_phase_init and the flag clears. Dispatch on next_status:
  - NOP: go to FETCH.
  - RAM_WRITE: ram_addr<=addr_register_out; ram_wdata<=acc if data_from=000, data_register if 001, else 0; go to RAM_WR.
  - RAM_READ: ram_addr<=addr_register_out; go to RAM_RD.
  - ROM_READ: go to ROM_OPND.
  - PROCESS: alu_start pulse (1 cycle); go to ALU_WAIT.
  - NOT_DONE: stay in DECODE, run_phase+1.
  - 101/110: illegal_op pulse, go to FETCH.
- RAM_WR: ram_req=ram_we=1. On ram_ack go to FETCH. RAM_WRITE always terminates the instruction.
- RAM_RD: ram_req=1, ram_we=0. On ram_ack: data_register<=ram_rdata, run_phase+1, go to DECODE.
- ROM_OPND: rom_req=1, rom_addr=pc. On rom_ack: data_register<=rom_rdata, pc+1, run_phase+1, go to DECODE.
- ALU_WAIT: on alu_done: run_phase+1, go to DECODE.
- run_phase increments wrap 7->0.
- Timeout: the wait counter clears on entry to any wait state and increments each cycle without completion. At ACK_TIMEOUT: bus_err pulse, request dropped, go to FETCH. A failed FETCH leaves pc unchanged (retry). A failed ROM_OPND leaves pc unchanged. No register updates occur on abort.
- ack arriving in the same cycle the timeout is reached: ack wins, no bus_err.
- Latency: NOP = 2 cycles (zero-wait ROM). MOV Rn,A = 3 cycles.
- Reset mid-transfer: requests drop immediately (async). Any ack arriving after reset is ignored.

Test Plan:
- ROM returns 8'h00 at pc 0 with rom_ack tied high -> rom_req high from the first cycle; pc=1,2,3 on successive 2-cycle instructions; no RAM activity.
- Opcode 8'hFB; decoder returns RAM_WRITE, init 4, addr 8'h0B, data_from 000; acc=8'h5A -> ram_req=ram_we=1, ram_addr=8'h0B, ram_wdata=8'h5A, run_phase=4; next FETCH from pc+1.
- ROM_READ step with rom_rdata=8'h3C, then RAM_WRITE with data_from 001 -> data_register=8'h3C, pc advanced by 2, ram_wdata=8'h3C, run_phase init+1.
- rom_ack held low with ACK_TIMEOUT=15 -> single bus_err pulse 15 cycles after the request starts; pc unchanged; FETCH retried.
- next_status=3'b101 in DECODE -> single illegal_op pulse; FETCH next cycle; no RAM/ALU strobes.
- rst_n low during RAM_RD with ram_ack arriving 1 cycle later -> ram_req low immediately; data_register=0; pc=RESET_PC; normal fetch after release.

Source files
------------

// File: rtl/cpu_exec_sequencer.sv
// Per-instruction execution sequencer for the 8051 core: fetches opcodes, steps the
// decoder through its phases, and owns the PC plus the single ROM/RAM request handshakes.
module cpu_exec_sequencer #(
   parameter int unsigned     PC_W        = 16,
   parameter logic [PC_W-1:0] RESET_PC    = '0,
   parameter logic [7:0]      ACK_TIMEOUT = 8'd15
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [2:0]      next_status,
   input  logic [2:0]      run_phase_init,
   input  logic [2:0]      data_from,
   input  logic [7:0]      addr_register_out,
   input  logic [7:0]      acc,
   input  logic            rom_ack,
   input  logic [7:0]      rom_rdata,
   input  logic            ram_ack,
   input  logic [7:0]      ram_rdata,
   input  logic            alu_done,
   output logic [7:0]      instruction,
   output logic [2:0]      run_phase,
   output logic [PC_W-1:0] pc,
   output logic            rom_req,
   output logic [PC_W-1:0] rom_addr,
   output logic            ram_req,
   output logic            ram_we,
   output logic [7:0]      ram_addr,
   output logic [7:0]      ram_wdata,
   output logic [7:0]      data_register,
   output logic            alu_start,
   output logic            bus_err,
   output logic            illegal_op
);

   localparam logic [2:0] NS_NOP       = 3'b000;
   localparam logic [2:0] NS_RAM_READ  = 3'b001;
   localparam logic [2:0] NS_ROM_READ  = 3'b010;
   localparam logic [2:0] NS_PROCESS   = 3'b011;
   localparam logic [2:0] NS_RAM_WRITE = 3'b100;
   localparam logic [2:0] NS_NOT_DONE  = 3'b111;

   typedef enum logic [2:0] {
      S_FETCH,
      S_DECODE,
      S_ROM_OPND,
      S_RAM_RD,
      S_RAM_WR,
      S_ALU_WAIT
   } state_t;

   state_t          state, state_nxt;
   logic [PC_W-1:0] pc_nxt;
   logic [7:0]      instr_nxt, dreg_nxt, raddr_nxt, wdata_nxt;
   logic [2:0]      phase_nxt, phase_base;
   logic [7:0]      wait_cnt, wait_nxt;
   logic            first_dec, first_nxt;
   logic            rom_req_nxt, ram_req_nxt, ram_we_nxt;
   logic            alu_start_nxt, bus_err_nxt, illegal_nxt;
   logic            stalled;

   assign rom_addr = pc;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= S_FETCH;
         pc            <= RESET_PC;
         instruction   <= 8'h00;
         run_phase     <= 3'd0;
         data_register <= 8'h00;
         wait_cnt      <= 8'h00;
         first_dec     <= 1'b0;
         rom_req       <= 1'b0;
         ram_req       <= 1'b0;
         ram_we        <= 1'b0;
         ram_addr      <= 8'h00;
         ram_wdata     <= 8'h00;
         alu_start     <= 1'b0;
         bus_err       <= 1'b0;
         illegal_op    <= 1'b0;
      end else begin
         state         <= state_nxt;
         pc            <= pc_nxt;
         instruction   <= instr_nxt;
         run_phase     <= phase_nxt;
         data_register <= dreg_nxt;
         wait_cnt      <= wait_nxt;
         first_dec     <= first_nxt;
         rom_req       <= rom_req_nxt;
         ram_req       <= ram_req_nxt;
         ram_we        <= ram_we_nxt;
         ram_addr      <= raddr_nxt;
         ram_wdata     <= wdata_nxt;
         alu_start     <= alu_start_nxt;
         bus_err       <= bus_err_nxt;
         illegal_op    <= illegal_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      pc_nxt        = pc;
      instr_nxt     = instruction;
      phase_nxt     = run_phase;
      dreg_nxt      = data_register;
      raddr_nxt     = ram_addr;
      wdata_nxt     = ram_wdata;
      wait_nxt      = 8'h00;
      first_nxt     = first_dec;
      rom_req_nxt   = rom_req;
      ram_req_nxt   = ram_req;
      ram_we_nxt    = ram_we;
      alu_start_nxt = 1'b0;
      bus_err_nxt   = 1'b0;
      illegal_nxt   = 1'b0;
      stalled       = 1'b0;
      phase_base    = first_dec ? run_phase_init : run_phase;

      case (state)
         S_FETCH: begin
            // rom_req is only low here right after reset or an abort; raise it first
            if (!rom_req) begin
               rom_req_nxt = 1'b1;
            end else if (rom_ack) begin
               instr_nxt   = rom_rdata;
               pc_nxt      = pc + PC_W'(1);
               phase_nxt   = 3'd0;
               first_nxt   = 1'b1;
               rom_req_nxt = 1'b0;
               state_nxt   = S_DECODE;
            end else begin
               stalled = 1'b1;
            end
         end
         S_DECODE: begin
            phase_nxt = phase_base;
            first_nxt = 1'b0;
            case (next_status)
               NS_NOP: begin
                  rom_req_nxt = 1'b1;
                  state_nxt   = S_FETCH;
               end
               NS_RAM_WRITE: begin
                  raddr_nxt = addr_register_out;
                  case (data_from)
                     3'b000:  wdata_nxt = acc;
                     3'b001:  wdata_nxt = data_register;
                     default: wdata_nxt = 8'h00;
                  endcase
                  ram_req_nxt = 1'b1;
                  ram_we_nxt  = 1'b1;
                  state_nxt   = S_RAM_WR;
               end
               NS_RAM_READ: begin
                  raddr_nxt   = addr_register_out;
                  ram_req_nxt = 1'b1;
                  ram_we_nxt  = 1'b0;
                  state_nxt   = S_RAM_RD;
               end
               NS_ROM_READ: begin
                  rom_req_nxt = 1'b1;
                  state_nxt   = S_ROM_OPND;
               end
               NS_PROCESS: begin
                  alu_start_nxt = 1'b1;
                  state_nxt     = S_ALU_WAIT;
               end
               NS_NOT_DONE: begin
                  phase_nxt = phase_base + 3'd1;
               end
               default: begin
                  illegal_nxt = 1'b1;
                  rom_req_nxt = 1'b1;
                  state_nxt   = S_FETCH;
               end
            endcase
         end
         S_ROM_OPND: begin
            if (rom_ack) begin
               dreg_nxt    = rom_rdata;
               pc_nxt      = pc + PC_W'(1);
               phase_nxt   = run_phase + 3'd1;
               rom_req_nxt = 1'b0;
               state_nxt   = S_DECODE;
            end else begin
               stalled = 1'b1;
            end
         end
         S_RAM_RD: begin
            if (ram_ack) begin
               dreg_nxt    = ram_rdata;
               phase_nxt   = run_phase + 3'd1;
               ram_req_nxt = 1'b0;
               state_nxt   = S_DECODE;
            end else begin
               stalled = 1'b1;
            end
         end
         S_RAM_WR: begin
            if (ram_ack) begin
               ram_req_nxt = 1'b0;
               ram_we_nxt  = 1'b0;
               rom_req_nxt = 1'b1;
               state_nxt   = S_FETCH;
            end else begin
               stalled = 1'b1;
            end
         end
         S_ALU_WAIT: begin
            if (alu_done) begin
               phase_nxt = run_phase + 3'd1;
               state_nxt = S_DECODE;
            end else begin
               stalled = 1'b1;
            end
         end
         default: begin
            state_nxt = S_FETCH;
         end
      endcase

      // A completing ack takes priority over a timeout reached in the same cycle
      if (stalled) begin
         if (wait_cnt == ACK_TIMEOUT - 8'd1) begin
            bus_err_nxt = 1'b1;
            rom_req_nxt = 1'b0;
            ram_req_nxt = 1'b0;
            ram_we_nxt  = 1'b0;
            pc_nxt      = pc;
            dreg_nxt    = data_register;
            phase_nxt   = run_phase;
            state_nxt   = S_FETCH;
         end else begin
            wait_nxt = wait_cnt + 8'd1;
         end
      end
   end

endmodule

// File: tb/tb_cpu_exec_sequencer.sv
// Bench for cpu_exec_sequencer: directed literal scenarios plus a randomized
// instruction stream compared cycle by cycle against a transaction-level timeline model.
module tb_cpu_exec_sequencer;

   localparam int T = 15;
   localparam logic [2:0] NS_NOP = 3'b000, NS_RAM_READ = 3'b001, NS_ROM_READ = 3'b010;
   localparam logic [2:0] NS_PROCESS = 3'b011, NS_RAM_WRITE = 3'b100, NS_NOT_DONE = 3'b111;
   localparam int K_ROM = 0, K_RDR = 1, K_WRR = 2, K_ALU = 3;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [2:0]  next_status, run_phase_init, data_from;
   logic [7:0]  addr_register_out, acc, rom_rdata, ram_rdata;
   logic        rom_ack, ram_ack, alu_done;
   logic [7:0]  instruction, ram_addr, ram_wdata, data_register;
   logic [2:0]  run_phase;
   logic [15:0] pc, rom_addr;
   logic        rom_req, ram_req, ram_we, alu_start, bus_err, illegal_op;

   cpu_exec_sequencer #(.PC_W(16), .RESET_PC(16'h0000), .ACK_TIMEOUT(8'd15)) dut (
      .clk(clk), .rst_n(rst_n), .next_status(next_status), .run_phase_init(run_phase_init),
      .data_from(data_from), .addr_register_out(addr_register_out), .acc(acc),
      .rom_ack(rom_ack), .rom_rdata(rom_rdata), .ram_ack(ram_ack), .ram_rdata(ram_rdata),
      .alu_done(alu_done), .instruction(instruction), .run_phase(run_phase), .pc(pc),
      .rom_req(rom_req), .rom_addr(rom_addr), .ram_req(ram_req), .ram_we(ram_we),
      .ram_addr(ram_addr), .ram_wdata(ram_wdata), .data_register(data_register),
      .alu_start(alu_start), .bus_err(bus_err), .illegal_op(illegal_op)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       rom_ack;
      logic [7:0] rom_rdata;
      logic       ram_ack;
      logic [7:0] ram_rdata;
      logic       alu_done;
      logic [2:0] ns;
      logic [2:0] init;
      logic [2:0] df;
      logic [7:0] addr;
      logic [7:0] acc;
   } in_t;

   typedef struct packed {
      logic        rom_req, ram_req, ram_we, alu_start, bus_err, illegal;
      logic [15:0] pc;
      logic [15:0] rom_addr;
      logic [7:0]  instr;
      logic [2:0]  phase;
      logic [7:0]  dreg, raddr, wdata;
   } out_t;

   int errors = 0;
   int checks = 0;

   in_t  in_q[$];
   out_t exp_q[$];

   // architectural view of the sequencer as the model tracks it
   logic [15:0] m_pc;
   logic [7:0]  m_instr, m_dreg, m_raddr, m_wdata;
   logic [2:0]  m_phase;
   logic        m_first, p_alu, p_berr, p_ill;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h required %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input in_t i);
      rom_ack = i.rom_ack;   rom_rdata = i.rom_rdata;
      ram_ack = i.ram_ack;   ram_rdata = i.ram_rdata;
      alu_done = i.alu_done; next_status = i.ns;
      run_phase_init = i.init; data_from = i.df;
      addr_register_out = i.addr; acc = i.acc;
   endtask

   function automatic in_t rand_in();
      in_t i;
      i.rom_ack   = 1'($urandom_range(0, 1));
      i.rom_rdata = 8'($urandom);
      i.ram_ack   = 1'($urandom_range(0, 1));
      i.ram_rdata = 8'($urandom);
      i.alu_done  = 1'($urandom_range(0, 1));
      i.ns        = 3'($urandom);
      i.init      = 3'($urandom);
      i.df        = 3'($urandom);
      i.addr      = 8'($urandom);
      i.acc       = 8'($urandom);
      return i;
   endfunction

   function automatic out_t dut_out();
      out_t o;
      o.rom_req = rom_req; o.ram_req = ram_req; o.ram_we = ram_we;
      o.alu_start = alu_start; o.bus_err = bus_err; o.illegal = illegal_op;
      o.pc = pc; o.rom_addr = rom_addr; o.instr = instruction; o.phase = run_phase;
      o.dreg = data_register; o.raddr = ram_addr; o.wdata = ram_wdata;
      return o;
   endfunction

   // one timeline cycle: expected outputs are the model state before this cycle's edge
   task automatic emit(input logic rr, input logic mr, input logic mw, input in_t i);
      out_t o;
      o.rom_req = rr; o.ram_req = mr; o.ram_we = mw;
      o.alu_start = p_alu; o.bus_err = p_berr; o.illegal = p_ill;
      o.pc = m_pc; o.rom_addr = m_pc; o.instr = m_instr; o.phase = m_phase;
      o.dreg = m_dreg; o.raddr = m_raddr; o.wdata = m_wdata;
      exp_q.push_back(o);
      in_q.push_back(i);
      p_alu = 1'b0; p_berr = 1'b0; p_ill = 1'b0;
   endtask

   // one wait phase: a random number of stall cycles, then either an ack or a timeout
   task automatic xfer(input int kind, output bit ok, output logic [7:0] rd);
      in_t i;
      bit  to;
      int  d, n;
      to = 1'b0;
      d  = $urandom_range(0, 3);
      case ($urandom_range(0, 7))
         0: to = 1'b1;
         1: d = T - 1;
         default: ;
      endcase
      n  = to ? T : d + 1;
      rd = 8'h00;
      for (int c = 0; c < n; c++) begin
         bit last;
         i    = rand_in();
         last = !to && (c == n - 1);
         case (kind)
            K_ROM: begin i.rom_ack = last; rd = i.rom_rdata; end
            K_ALU: i.alu_done = last;
            default: begin i.ram_ack = last; rd = i.ram_rdata; end
         endcase
         emit(kind == K_ROM, kind == K_RDR || kind == K_WRR, kind == K_WRR, i);
      end
      ok = !to;
      if (to) p_berr = 1'b1;
   endtask

   task automatic gen_fetch(input bit low_first);
      bit         ok;
      logic [7:0] rd;
      if (low_first) emit(1'b0, 1'b0, 1'b0, rand_in());
      xfer(K_ROM, ok, rd);
      while (!ok) begin
         emit(1'b0, 1'b0, 1'b0, rand_in());
         xfer(K_ROM, ok, rd);
      end
      m_instr = rd; m_pc = m_pc + 16'd1; m_phase = 3'd0; m_first = 1'b1;
   endtask

   task automatic gen_instr(output bit low_first);
      int         nmid, s;
      bit         done, ok;
      in_t        i;
      logic [2:0] ns;
      logic [7:0] rd;
      nmid = $urandom_range(0, 3);
      s = 0; done = 1'b0; low_first = 1'b0;
      while (!done) begin
         i = rand_in();
         if (s < nmid) begin
            case ($urandom_range(0, 3))
               0: ns = NS_NOT_DONE;
               1: ns = NS_RAM_READ;
               2: ns = NS_ROM_READ;
               default: ns = NS_PROCESS;
            endcase
         end else begin
            case ($urandom_range(0, 3))
               0: ns = NS_NOP;
               3: ns = 3'($urandom_range(5, 6));
               default: ns = NS_RAM_WRITE;
            endcase
         end
         s++;
         i.ns = ns;
         if ($urandom_range(0, 2) != 2) i.df = 3'($urandom_range(0, 1));
         emit(1'b0, 1'b0, 1'b0, i);
         if (m_first) m_phase = i.init;
         m_first = 1'b0;
         case (ns)
            NS_NOT_DONE: m_phase = m_phase + 3'd1;
            NS_RAM_READ: begin
               m_raddr = i.addr;
               xfer(K_RDR, ok, rd);
               if (ok) begin m_dreg = rd; m_phase = m_phase + 3'd1; end
               else begin low_first = 1'b1; done = 1'b1; end
            end
            NS_ROM_READ: begin
               xfer(K_ROM, ok, rd);
               if (ok) begin m_dreg = rd; m_pc = m_pc + 16'd1; m_phase = m_phase + 3'd1; end
               else begin low_first = 1'b1; done = 1'b1; end
            end
            NS_PROCESS: begin
               p_alu = 1'b1;
               xfer(K_ALU, ok, rd);
               if (ok) m_phase = m_phase + 3'd1;
               else begin low_first = 1'b1; done = 1'b1; end
            end
            NS_NOP: done = 1'b1;
            NS_RAM_WRITE: begin
               m_raddr = i.addr;
               m_wdata = (i.df == 3'd0) ? i.acc : (i.df == 3'd1) ? m_dreg : 8'h00;
               xfer(K_WRR, ok, rd);
               low_first = !ok;
               done = 1'b1;
            end
            default: begin p_ill = 1'b1; done = 1'b1; end
         endcase
      end
   endtask

   task automatic do_reset();
      in_t z;
      z = '0;
      drive(z);
      rst_n = 1'b0;
      step();
      step();
      rst_n = 1'b1;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout required completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int  n;
      bit  lf;
      out_t act;

      // ---- directed: reset values and zero-wait NOP stream
      rst_n = 1'b0;
      drive(in_t'('0));
      step(); step();
      chk("rst_rom_req", rom_req, 0);
      chk("rst_pc", pc, 0);
      chk("rst_outputs", {ram_req, ram_we, alu_start, bus_err, illegal_op, run_phase,
                          instruction, data_register, ram_addr, ram_wdata}, 0);
      rst_n = 1'b1;
      rom_ack = 1'b1; rom_rdata = 8'h00; next_status = NS_NOP;
      step();
      chk("nop_c1_rom_req", rom_req, 1);
      chk("nop_c1_rom_addr", rom_addr, 0);
      step();
      chk("nop_c2_pc", pc, 1);
      chk("nop_c2_rom_req", rom_req, 0);
      chk("nop_c2_ram_req", ram_req, 0);
      step(); step();
      chk("nop_c4_pc", pc, 2);
      step(); step();
      chk("nop_c6_pc", pc, 3);
      chk("nop_c6_ram_req", ram_req, 0);

      // ---- directed: MOV Rn,A style RAM write
      rom_rdata = 8'hFB;
      step(); step();
      chk("wr_instr", instruction, 8'hFB);
      chk("wr_decode_pc", pc, 4);
      next_status = NS_RAM_WRITE; run_phase_init = 3'd4; addr_register_out = 8'h0B;
      data_from = 3'b000; acc = 8'h5A; rom_ack = 1'b0;
      step();
      chk("wr_req_we", {ram_req, ram_we}, 2'b11);
      chk("wr_addr", ram_addr, 8'h0B);
      chk("wr_wdata", ram_wdata, 8'h5A);
      chk("wr_phase", run_phase, 4);
      ram_ack = 1'b1;
      step();
      chk("wr_next_fetch", {rom_req, ram_req, rom_addr}, {2'b10, 16'd4});

      // ---- directed: ROM operand then RAM write from data_register
      ram_ack = 1'b0; rom_ack = 1'b1; rom_rdata = 8'h22;
      next_status = NS_ROM_READ; run_phase_init = 3'd2;
      step();
      rom_ack = 1'b0;
      step();
      chk("opnd_req", {rom_req, rom_addr, run_phase}, {1'b1, 16'd5, 3'd2});
      rom_ack = 1'b1; rom_rdata = 8'h3C;
      step();
      chk("opnd_dreg", data_register, 8'h3C);
      chk("opnd_pc", pc, 6);
      next_status = NS_RAM_WRITE; data_from = 3'b001; addr_register_out = 8'h11;
      acc = 8'hAA; rom_ack = 1'b0;
      step();
      chk("opnd_wdata", ram_wdata, 8'h3C);
      chk("opnd_phase", run_phase, 3);
      ram_ack = 1'b1;
      step();
      ram_ack = 1'b0; rom_ack = 1'b0;

      // ---- directed: fetch timeout and retry
      n = 0;
      while (bus_err !== 1'b1 && n < 40) begin
         step();
         n++;
      end
      chk("to_cycles", n, T);
      chk("to_dropped", {rom_req, pc}, {1'b0, 16'd6});
      step();
      chk("to_retry", {bus_err, rom_req, pc}, {1'b0, 1'b1, 16'd6});

      // ---- directed: illegal status code
      rom_ack = 1'b1; rom_rdata = 8'h77;
      step();
      next_status = 3'b101; rom_ack = 1'b0;
      step();
      chk("ill_pulse", {illegal_op, rom_req, alu_start, ram_req, pc}, {4'b1100, 16'd7});
      step();
      chk("ill_single", illegal_op, 0);

      // ---- randomized stream against the timeline model
      m_pc = 16'h0000; m_instr = 8'h00; m_dreg = 8'h00; m_raddr = 8'h00; m_wdata = 8'h00;
      m_phase = 3'd0; m_first = 1'b0; p_alu = 1'b0; p_berr = 1'b0; p_ill = 1'b0;
      gen_fetch(1'b1);
      for (int k = 0; k < 60; k++) begin
         gen_instr(lf);
         gen_fetch(lf);
      end
      do_reset();
      for (int k = 0; k < exp_q.size(); k++) begin
         act = dut_out();
         checks++;
         if (act !== exp_q[k]) begin
            errors++;
            $display("FAIL cycle_%0d: got %h required %h", k, act, exp_q[k]);
         end
         drive(in_q[k]);
         step();
      end

      // ---- directed: reset during a RAM read
      do_reset();
      rom_ack = 1'b1; rom_rdata = 8'h55;
      step();
      step();
      next_status = NS_RAM_READ; addr_register_out = 8'h20; rom_ack = 1'b0;
      step();
      chk("rr_req", ram_req, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("rr_async_drop", {ram_req, rom_req, pc, data_register}, 0);
      ram_ack = 1'b1; ram_rdata = 8'hEE;
      step();
      chk("rr_in_reset", {ram_req, data_register}, 0);
      rst_n = 1'b1;
      rom_ack = 1'b1; rom_rdata = 8'h00; next_status = NS_NOP;
      step();
      chk("rr_refetch", {rom_req, ram_req, data_register}, {2'b10, 8'h00});
      step();
      chk("rr_decode", {pc, data_register}, {16'd1, 8'h00});

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
